color_sel_reg: RTL and testbench



---
 rtl/color_sel_reg.sv | 106 ++++++++++
 tb/tb_color_sel_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/color_sel_reg.sv
// rtl/color_sel_reg.sv - registered colour selector: sync, debounce, mode, frame-aligned commit, blanking
module color_sel_reg #(
  parameter int COLOR_W   = 3,
  parameter int DEB_COUNT = 250000,
  parameter int DEB_W     = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COLOR_W-1:0] color_sw,
  input  logic [1:0]         mode,
  input  logic               frame_start,
  input  logic               video_on,
  output logic [COLOR_W-1:0] px_color,
  output logic               color_changed
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_COUNT - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_BLACK  = 2'b11
  } mode_t;

  logic [COLOR_W-1:0] r_sync1;
  logic [COLOR_W-1:0] r_sync2;
  logic [COLOR_W-1:0] r_cand;
  logic [DEB_W-1:0]   r_cnt;
  logic [COLOR_W-1:0] r_stable;
  logic [COLOR_W-1:0] r_auto;
  logic [COLOR_W-1:0] r_committed;
  logic [COLOR_W-1:0] r_px;
  logic               r_changed;

  logic [COLOR_W-1:0] w_pending;
  mode_t              w_mode;

  assign w_mode = mode_t'(mode);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= color_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Counter saturates at DEB_MAX so stable keeps being refreshed from the held candidate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt < DEB_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_stable <= r_cand;
    end
  end

  always_comb begin
    w_pending = '0;
    case (w_mode)
      MODE_DIRECT: w_pending = r_stable;
      MODE_INVERT: w_pending = ~r_stable;
      MODE_AUTO:   w_pending = r_auto;
      MODE_BLACK:  w_pending = '0;
      default:     w_pending = '0;
    endcase
  end

  // Commit uses pre-edge auto value; the increment shows up at the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_auto      <= '0;
      r_committed <= '0;
      r_changed   <= 1'b0;
    end else begin
      if (frame_start && (w_mode == MODE_AUTO)) begin
        r_auto <= r_auto + 1'b1;
      end
      if (frame_start) begin
        r_committed <= w_pending;
      end
      r_changed <= frame_start && (w_pending != r_committed);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_px <= '0;
    end else begin
      r_px <= video_on ? r_committed : '0;
    end
  end

  assign px_color      = r_px;
  assign color_changed = r_changed;

endmodule

// File: tb/tb_color_sel_reg.sv
// tb/tb_color_sel_reg.sv - scoreboard bench for color_sel_reg with short debounce
module tb_color_sel_reg;

  localparam int COLOR_W = 3;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [COLOR_W-1:0] color_sw;
  logic [1:0]         mode;
  logic               frame_start;
  logic               video_on;
  logic [COLOR_W-1:0] px_color;
  logic               color_changed;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string              tag;
    logic [COLOR_W-1:0] px;
    logic               chg;
  } exp_t;

  exp_t sb_q[$];

  color_sel_reg #(
    .COLOR_W  (COLOR_W),
    .DEB_COUNT(4),
    .DEB_W    (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .color_sw     (color_sw),
    .mode         (mode),
    .frame_start  (frame_start),
    .video_on     (video_on),
    .px_color     (px_color),
    .color_changed(color_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [COLOR_W-1:0] px, input logic chg);
    exp_t e;
    e.tag = tag;
    e.px  = px;
    e.chg = chg;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_px"}, 32'(px_color), 32'(e.px));
      chk({e.tag, "_chg"}, 32'(color_changed), 32'(e.chg));
    end
  endtask

  task automatic step(input string tag, input logic [COLOR_W-1:0] px, input logic chg);
    push_exp(tag, px, chg);
    tick();
    drain();
  endtask

  // Commit edge shows the old px and the change flag; the next edge shows the new px.
  task automatic frame(input string tag, input logic [COLOR_W-1:0] old_px,
                       input logic [COLOR_W-1:0] new_px, input logic chg);
    frame_start = 1'b1;
    step({tag, "_fs"}, old_px, chg);
    frame_start = 1'b0;
    step({tag, "_out"}, new_px, 1'b0);
  endtask

  initial begin
    logic [COLOR_W-1:0] prev;
    logic [COLOR_W-1:0] cur;

    reset_n     = 1'b0;
    color_sw    = '0;
    mode        = 2'b00;
    frame_start = 1'b0;
    video_on    = 1'b1;
    #1;
    push_exp("rst0", 3'b000, 1'b0);
    drain();
    tick();
    tick();
    reset_n = 1'b1;
    step("rst_rel", 3'b000, 1'b0);

    // glitch 000->111 for three cycles, then back
    color_sw = 3'b111;
    for (int i = 0; i < 3; i++) step("glitch_hi", 3'b000, 1'b0);
    color_sw = 3'b000;
    for (int i = 0; i < 8; i++) step("glitch_lo", 3'b000, 1'b0);
    frame("glitch_f1", 3'b000, 3'b000, 1'b0);
    frame("glitch_f2", 3'b000, 3'b000, 1'b0);

    // clean debounce to 110, stable after 7 edges
    color_sw = 3'b110;
    for (int i = 0; i < 7; i++) step("deb_wait", 3'b000, 1'b0);
    frame("deb_commit", 3'b000, 3'b110, 1'b1);
    step("deb_hold", 3'b110, 1'b0);

    // modes with stable=011
    color_sw = 3'b011;
    for (int i = 0; i < 8; i++) step("mode_settle", 3'b110, 1'b0);
    mode = 2'b01;
    frame("mode_inv", 3'b110, 3'b100, 1'b1);
    mode = 2'b11;
    frame("mode_black", 3'b100, 3'b000, 1'b1);
    mode = 2'b10;
    prev = 3'b000;
    for (int i = 0; i < 9; i++) begin
      cur = 3'(i);
      frame($sformatf("auto%0d", i), prev, cur, cur != prev);
      prev = cur;
    end

    // settle 010 without committing, then commit it and check auto held at 1
    color_sw = 3'b010;
    mode = 2'b00;
    for (int i = 0; i < 8; i++) step("tear_settle", 3'b000, 1'b0);
    frame("tear_c010", 3'b000, 3'b010, 1'b1);
    mode = 2'b10;
    frame("auto_held", 3'b010, 3'b001, 1'b1);
    mode = 2'b00;
    frame("tear_back", 3'b001, 3'b010, 1'b1);

    // switches change mid-frame: output frozen until next frame_start
    color_sw = 3'b101;
    for (int i = 0; i < 10; i++) step("tear_frozen", 3'b010, 1'b0);
    video_on = 1'b0;
    step("blank1", 3'b000, 1'b0);
    step("blank2", 3'b000, 1'b0);
    video_on = 1'b1;
    step("unblank", 3'b010, 1'b0);
    frame("tear_next", 3'b010, 3'b101, 1'b1);

    // stable update coincides with frame_start on edge 7
    color_sw = 3'b010;
    for (int i = 0; i < 6; i++) step("sim_wait", 3'b101, 1'b0);
    frame("sim_old", 3'b101, 3'b101, 1'b0);
    frame("sim_new", 3'b101, 3'b010, 1'b1);
    frame("sim_same", 3'b010, 3'b010, 1'b0);

    // asynchronous reset mid-cycle
    color_sw = 3'b101;
    #2;
    reset_n = 1'b0;
    #1;
    push_exp("arst_now", 3'b000, 1'b0);
    drain();
    step("arst_hold", 3'b000, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step("arst_post", 3'b000, 1'b0);
    frame("arst_commit", 3'b000, 3'b101, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
